// File: rtl/fsm_sequencer_if.sv
// fsm_sequencer_if: control, ROM and status signals of the phase sequencer.
`default_nettype none

interface fsm_sequencer_if;
  logic       en;
  logic       cnt_rst;
  logic       jump;
  logic [3:0] jump_addr;
  logic [7:0] rom_data;
  logic [3:0] rom_addr;
  logic [2:0] state;
  logic [3:0] count;
  logic [1:0] opcode;
  logic [5:0] operand;
  logic       wrap;
  logic       halted;

  modport master (
    output en, cnt_rst, jump, jump_addr, rom_data,
    input  rom_addr, state, count, opcode, operand, wrap, halted
  );

  modport slave (
    input  en, cnt_rst, jump, jump_addr, rom_data,
    output rom_addr, state, count, opcode, operand, wrap, halted
  );
endinterface

`default_nettype wire

// File: rtl/fsm_sequencer.sv
// fsm_sequencer: FETCH/DECODE/EXEC/WB phase sequencer with 4-bit program counter.
// Revision: 1.0
`default_nettype none

module fsm_sequencer #(
  parameter logic [5:0] HALT_OPERAND = 6'h3F
) (
  input  wire logic       clk,
  input  wire logic       rst,
  fsm_sequencer_if.slave  bus
);

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    WB     = 3'd3,
    HALT   = 3'd4
  } state_t;

  // Plain vector so that out-of-range codes 5-7 are representable and recoverable.
  logic [2:0] r_state;
  logic [3:0] r_count;
  logic [1:0] r_opcode;
  logic [5:0] r_operand;
  logic       r_wrap;
  logic       r_halted;

  state_t     w_next;
  logic       w_latch;
  logic       w_cnt_upd;

  always_comb begin
    w_next    = FETCH;
    w_latch   = 1'b0;
    w_cnt_upd = 1'b0;
    case (r_state)
      FETCH: begin
        w_next  = DECODE;
        w_latch = 1'b1;
      end
      DECODE: begin
        if (r_opcode == 2'b11 && r_operand == HALT_OPERAND) w_next = HALT;
        else                                               w_next = EXEC;
      end
      EXEC:    w_next = WB;
      WB: begin
        w_next    = FETCH;
        w_cnt_upd = 1'b1;
      end
      HALT:    w_next = HALT;
      default: w_next = FETCH;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= FETCH;
      r_count   <= 4'd0;
      r_opcode  <= 2'd0;
      r_operand <= 6'd0;
      r_wrap    <= 1'b0;
      r_halted  <= 1'b0;
    end else if (bus.en) begin
      if (bus.cnt_rst) begin
        // Clear/restart wins over every phase action; the latched instruction is kept.
        r_state  <= FETCH;
        r_count  <= 4'd0;
        r_wrap   <= 1'b0;
        r_halted <= 1'b0;
      end else begin
        r_state  <= w_next;
        r_halted <= (w_next == HALT);
        r_wrap   <= 1'b0;
        if (w_latch) begin
          r_opcode  <= bus.rom_data[7:6];
          r_operand <= bus.rom_data[5:0];
        end
        if (w_cnt_upd) begin
          if (bus.jump) begin
            r_count <= bus.jump_addr;
          end else begin
            r_count <= r_count + 4'd1;
            r_wrap  <= (r_count == 4'hF);
          end
        end
      end
    end
  end

  assign bus.rom_addr = r_count;
  assign bus.state    = r_state;
  assign bus.count    = r_count;
  assign bus.opcode   = r_opcode;
  assign bus.operand  = r_operand;
  assign bus.wrap     = r_wrap;
  assign bus.halted   = r_halted;

endmodule

`default_nettype wire

// File: tb/tb_fsm_sequencer.sv
// tb_fsm_sequencer: directed self-checking bench for fsm_sequencer.
`default_nettype none

module tb_fsm_sequencer;

  logic clk;
  logic rst;
  logic [7:0] rom [0:15];
  int checks;
  int failures;

  fsm_sequencer_if bus ();

  fsm_sequencer #(.HALT_OPERAND(6'h3F)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  assign bus.rom_data = rom[bus.rom_addr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Leaves the bench at a negedge with the DUT in cycle 1 (FETCH, count 0), en high.
  task automatic do_reset();
    rst = 1'b1;
    bus.en = 1'b0;
    bus.cnt_rst = 1'b0;
    bus.jump = 1'b0;
    bus.jump_addr = 4'd0;
    for (int i = 0; i < 16; i++) rom[i] = 8'h00;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    bus.en = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.en = 1'b1;
    bus.cnt_rst = 1'b0;
    bus.jump = 1'b0;
    bus.jump_addr = 4'd0;
    for (int i = 0; i < 16; i++) rom[i] = 8'hC3;
    #1;
    checks++; if (bus.state !== 3'd0) begin failures++; $display("FAIL reset_state got=%0d exp=0", bus.state); end
    checks++; if (bus.count !== 4'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", bus.count); end
    checks++; if (bus.opcode !== 2'd0) begin failures++; $display("FAIL reset_opcode got=%0d exp=0", bus.opcode); end
    checks++; if (bus.operand !== 6'd0) begin failures++; $display("FAIL reset_operand got=%0h exp=0", bus.operand); end
    checks++; if (bus.wrap !== 1'b0) begin failures++; $display("FAIL reset_wrap got=%b exp=0", bus.wrap); end
    checks++; if (bus.halted !== 1'b0) begin failures++; $display("FAIL reset_halted got=%b exp=0", bus.halted); end
    checks++; if (bus.rom_addr !== 4'd0) begin failures++; $display("FAIL reset_rom_addr got=%0d exp=0", bus.rom_addr); end
    ticks(2);
    checks++; if (bus.state !== 3'd0) begin failures++; $display("FAIL reset_hold_state got=%0d exp=0", bus.state); end
  endtask

  task automatic test_sequencing();
    int wrap_cnt;
    int bad;
    logic [2:0] exp_state;
    logic [3:0] exp_count;
    do_reset();
    wrap_cnt = 0;
    bad = 0;
    for (int cyc = 1; cyc <= 65; cyc++) begin
      exp_state = 3'((cyc - 1) % 4);
      exp_count = 4'(((cyc - 1) / 4) % 16);
      checks++;
      if (bus.state !== exp_state || bus.count !== exp_count) begin
        failures++;
        $display("FAIL seq cycle=%0d state got=%0d exp=%0d count got=%0d exp=%0d",
                 cyc, bus.state, exp_state, bus.count, exp_count);
      end
      if (bus.wrap === 1'b1) wrap_cnt++;
      if (cyc < 65) tick();
    end
    checks++; if (wrap_cnt !== 1) begin failures++; $display("FAIL seq_wrap_count got=%0d exp=1", wrap_cnt); end
    checks++; if (bus.wrap !== 1'b1) begin failures++; $display("FAIL seq_wrap_at_65 got=%b exp=1", bus.wrap); end
    tick();
    checks++; if (bus.wrap !== 1'b0) begin failures++; $display("FAIL seq_wrap_one_cycle got=%b exp=0", bus.wrap); end
    checks++; if (bus.state !== 3'd1) begin failures++; $display("FAIL seq_state_66 got=%0d exp=1", bus.state); end
  endtask

  task automatic test_jump();
    do_reset();
    ticks(16);
    checks++; if (bus.count !== 4'd4 || bus.state !== 3'd0) begin failures++; $display("FAIL jump_setup count got=%0d exp=4 state got=%0d exp=0", bus.count, bus.state); end
    bus.jump = 1'b1;
    bus.jump_addr = 4'hA;
    ticks(3);
    bus.jump = 1'b0;
    tick();
    checks++; if (bus.count !== 4'd5) begin failures++; $display("FAIL jump_ignored_early got=%0d exp=5", bus.count); end
    bus.jump = 1'b1;
    ticks(4);
    checks++; if (bus.count !== 4'hA) begin failures++; $display("FAIL jump_count got=%0d exp=10", bus.count); end
    checks++; if (bus.rom_addr !== 4'hA) begin failures++; $display("FAIL jump_rom_addr got=%0d exp=10", bus.rom_addr); end
    checks++; if (bus.state !== 3'd0) begin failures++; $display("FAIL jump_state got=%0d exp=0", bus.state); end
    bus.jump = 1'b0;
    bus.jump_addr = 4'h0;
    ticks(3);
    bus.jump = 1'b1;
    tick();
    bus.jump = 1'b0;
    checks++; if (bus.count !== 4'h0 || bus.wrap !== 1'b0) begin failures++; $display("FAIL jump_to_zero count got=%0d exp=0 wrap got=%b exp=0", bus.count, bus.wrap); end
  endtask

  task automatic test_cnt_rst();
    do_reset();
    ticks(30);
    checks++; if (bus.state !== 3'd2 || bus.count !== 4'd7) begin failures++; $display("FAIL crst_setup state got=%0d exp=2 count got=%0d exp=7", bus.state, bus.count); end
    bus.cnt_rst = 1'b1;
    tick();
    bus.cnt_rst = 1'b0;
    checks++; if (bus.state !== 3'd0 || bus.count !== 4'd0) begin failures++; $display("FAIL crst_exec state got=%0d exp=0 count got=%0d exp=0", bus.state, bus.count); end
    ticks(3);
    checks++; if (bus.state !== 3'd3) begin failures++; $display("FAIL crst_wb_setup state got=%0d exp=3", bus.state); end
    bus.cnt_rst = 1'b1;
    bus.jump = 1'b1;
    bus.jump_addr = 4'd9;
    tick();
    bus.cnt_rst = 1'b0;
    bus.jump = 1'b0;
    checks++; if (bus.count !== 4'd0 || bus.state !== 3'd0) begin failures++; $display("FAIL crst_vs_jump count got=%0d exp=0 state got=%0d exp=0", bus.count, bus.state); end
  endtask

  task automatic test_halt();
    do_reset();
    rom[0] = 8'hFE;
    rom[1] = 8'hFF;
    ticks(2);
    checks++; if (bus.state !== 3'd2 || bus.halted !== 1'b0) begin failures++; $display("FAIL halt_fe_no_halt state got=%0d exp=2 halted got=%b exp=0", bus.state, bus.halted); end
    ticks(4);
    checks++; if (bus.state !== 3'd4 || bus.halted !== 1'b1) begin failures++; $display("FAIL halt_enter state got=%0d exp=4 halted got=%b exp=1", bus.state, bus.halted); end
    checks++; if (bus.opcode !== 2'b11 || bus.operand !== 6'h3F) begin failures++; $display("FAIL halt_latch opcode got=%0d exp=3 operand got=%0h exp=3f", bus.opcode, bus.operand); end
    ticks(20);
    checks++; if (bus.count !== 4'd1 || bus.state !== 3'd4 || bus.halted !== 1'b1) begin failures++; $display("FAIL halt_frozen count got=%0d exp=1 state got=%0d exp=4", bus.count, bus.state); end
    bus.cnt_rst = 1'b1;
    tick();
    bus.cnt_rst = 1'b0;
    checks++; if (bus.state !== 3'd0 || bus.count !== 4'd0 || bus.halted !== 1'b0) begin failures++; $display("FAIL halt_exit state got=%0d exp=0 count got=%0d exp=0 halted got=%b exp=0", bus.state, bus.count, bus.halted); end
    checks++; if (bus.opcode !== 2'b11 || bus.operand !== 6'h3F) begin failures++; $display("FAIL halt_exit_hold opcode got=%0d exp=3 operand got=%0h exp=3f", bus.opcode, bus.operand); end
  endtask

  task automatic test_stall();
    do_reset();
    ticks(13);
    checks++; if (bus.state !== 3'd1 || bus.count !== 4'd3) begin failures++; $display("FAIL stall_setup state got=%0d exp=1 count got=%0d exp=3", bus.state, bus.count); end
    bus.en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      bus.cnt_rst = (i == 2);
      tick();
      checks++;
      if (bus.state !== 3'd1 || bus.count !== 4'd3 || bus.wrap !== 1'b0 || bus.halted !== 1'b0) begin
        failures++;
        $display("FAIL stall_hold i=%0d state got=%0d exp=1 count got=%0d exp=3", i, bus.state, bus.count);
      end
    end
    bus.cnt_rst = 1'b0;
    bus.en = 1'b1;
    tick();
    checks++; if (bus.state !== 3'd2 || bus.count !== 4'd3) begin failures++; $display("FAIL stall_resume state got=%0d exp=2 count got=%0d exp=3", bus.state, bus.count); end
  endtask

  task automatic test_async_reset();
    do_reset();
    ticks(63);
    checks++; if (bus.state !== 3'd3 || bus.count !== 4'hF) begin failures++; $display("FAIL arst_setup state got=%0d exp=3 count got=%0d exp=15", bus.state, bus.count); end
    #2;
    rst = 1'b1;
    #1;
    checks++; if (bus.state !== 3'd0 || bus.count !== 4'd0 || bus.wrap !== 1'b0) begin failures++; $display("FAIL arst_immediate state got=%0d exp=0 count got=%0d exp=0 wrap got=%b exp=0", bus.state, bus.count, bus.wrap); end
    @(negedge clk);
    checks++; if (bus.wrap !== 1'b0 || bus.count !== 4'd0) begin failures++; $display("FAIL arst_no_wrap wrap got=%b exp=0 count got=%0d exp=0", bus.wrap, bus.count); end
    rst = 1'b0;
    tick();
    checks++; if (bus.state !== 3'd1 || bus.wrap !== 1'b0) begin failures++; $display("FAIL arst_first_edge state got=%0d exp=1 wrap got=%b exp=0", bus.state, bus.wrap); end
  endtask

  task automatic test_illegal_state();
    do_reset();
    bus.en = 1'b0;
    force dut.r_state = 3'd6;
    #1;
    release dut.r_state;
    #1;
    checks++; if (bus.state !== 3'd6) begin failures++; $display("FAIL illegal_forced state got=%0d exp=6", bus.state); end
    tick();
    checks++; if (bus.state !== 3'd6) begin failures++; $display("FAIL illegal_hold_disabled state got=%0d exp=6", bus.state); end
    bus.en = 1'b1;
    tick();
    checks++; if (bus.state !== 3'd0) begin failures++; $display("FAIL illegal_recover state got=%0d exp=0", bus.state); end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_sequencing();
    test_jump();
    test_cnt_rst();
    test_halt();
    test_stall();
    test_async_reset();
    test_illegal_state();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
